ram_arbiter_2p: RTL and testbench
=================================

Name: ram_arbiter_2p

Overview:
- Two-requester controller in front of the 4-word x 16-bit JK-flip-flop RAM (ram4x16 datapath).
- Runs a zero-fill sweep of all words after reset, then serves one read or write per transaction.
- Requesters are arbitrated round-robin, with a req/gnt/done handshake per port.
- Drives the RAM write/address/data lines glitch-free, because the RAM gates its storage clock with clk & write.

Parameters:
DATA_W, 16, data word width
ADDR_W, 2, address width; the RAM holds 2**ADDR_W words
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = go straight to IDLE

Ports:
clk  input  1  system clock; the FSM uses the rising edge
clear  input  1  asynchronous reset, active-low (0 = reset)
req0, req1  input  1  request from port 0 / port 1
we0, we1  input  1  1 = write, 0 = read; sampled with the request
addr0, addr1  input  ADDR_W  word address
wdata0, wdata1  input  DATA_W  write data
gnt0, gnt1  output  1  one-cycle grant pulse
done0, done1  output  1  one-cycle completion pulse
rdata  output  DATA_W  read result; valid while the done pulse of a read is high
busy  output  1  high in every state except IDLE
ram_write  output  1  to the RAM write input
ram_addr  output  ADDR_W  to the RAM address inputs
ram_wdata  output  DATA_W  to the RAM data inputs
ram_rdata  input  DATA_W  combinational RAM output

Behaviour:
- States and transitions (rising edge): INIT -> IDLE -> ACCESS -> RESP -> IDLE.
- Reset (clear=0, asynchronous):
  - state=INIT (or IDLE if INIT_EN=0), init_cnt=0, owner=0, last=1.
  - gnt*, done*, busy, ram_write, ram_addr, ram_wdata and rdata all go to 0 immediately.
  - Any access in flight is aborted; no done is issued for it.
- INIT:
  - Lasts 2**ADDR_W cycles; drives ram_write=1, ram_addr=init_cnt, ram_wdata=0.
  - init_cnt increments each cycle; moves to IDLE after the last address. Requests are ignored (no gnt).
- IDLE arbitration:
  - If exactly one req is high, that port wins.
  - If both are high, the port != last wins.
  - The winner's we, addr and wdata are latched at that edge.
  - owner and last are set to the winner; next state is ACCESS.
- ACCESS (1 cycle):
  - gnt<owner>=1.
  - RAM side: ram_addr=latched addr; if write, ram_write=1 and ram_wdata=latched data.
  - At the closing rising edge, a read captures ram_rdata into rdata.
- RESP (1 cycle):
  - done<owner>=1, busy=1, ram_write=0. Then IDLE.
  - rdata holds its value until the next read completes.
- Latency: req sampled at edge N -> gnt high in cycle N..N+1 -> done in the next cycle.
  - Port cycle-to-cycle service interval is 3 cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - It may deassert req after gnt.
  - A req still high when the FSM returns to IDLE counts as a new request.
- Glitch-free RAM drive:
  - ram_write, ram_addr and ram_wdata are registered on the FALLING edge of clk from the current state decode.
  - They are therefore stable through each high phase, and the RAM write occurs at the following rising edge.
  - Their async reset is the same clear.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1; the first grant after reset goes to port 0.
- A port never receives gnt and done in the same cycle; gnt0 and gnt1 are never high together.

Test Plan:
1. Release clear with INIT_EN=1 -> busy=1 for 4 cycles, ram_write=1 with ram_addr 0,1,2,3 and ram_wdata=0; then busy=0. A port-0 read of address 2 returns rdata=16'h0000 with done0.
2. Port 0 writes addr=1, wdata=16'hA5F0; then port 0 reads addr=1 -> gnt0 one cycle, done0 one cycle later; the read returns rdata=16'hA5F0; gnt1/done1 stay 0.
3. req0 and req1 high in the same cycle, both writes (addr 0 = 16'h1111, addr 3 = 16'h3333), held -> gnt0 then gnt1 three cycles later; read-back of addr 0 = 1111 and addr 3 = 3333.
4. Both ports requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1; each done follows its gnt by 1 cycle.
5. Assert clear during ACCESS of a write of 16'hFFFF to addr 2 -> ram_write, gnt and done drop immediately, no done issued; after release, INIT re-zeroes memory and a read of addr 2 returns 16'h0000.
6. Only port 1 requests, repeatedly reading addr 3 after a write of 16'h0F0F -> every request is granted to port 1 with no stall, and each done1 carries rdata=16'h0F0F.

Source files
------------

// File: rtl/ram_arbiter_2p_if.sv
// ram_arbiter_2p_if: requester-side bus of the two-port RAM arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : per-port request, driven by the requesters
//   gnt0/gnt1, done0/done1                          : one-cycle grant / completion pulses
//   rdata                                           : read result, valid with the done pulse of a read
//   busy                                            : arbiter not idle
interface ram_arbiter_2p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: round-robin controller for two requesters in front of a
// 2**ADDR_W x DATA_W RAM whose storage clock is gated by clk & write.
// After reset an optional sweep zero-fills every word, then one read or
// write is served per transaction (IDLE -> ACCESS -> RESP -> IDLE).
//   clk       : system clock, FSM on rising edge, RAM drive on falling edge
//   clear     : asynchronous reset, active-low
//   bus       : requester handshake (slave modport of ram_arbiter_2p_if)
//   ram_write : RAM write enable
//   ram_addr  : RAM address
//   ram_wdata : RAM write data
//   ram_rdata : combinational RAM read data
module ram_arbiter_2p #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              clear,
  ram_arbiter_2p_if.slave   bus,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              owner;
  logic              last;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic any_req;
  logic win;

  // Single requester wins outright; on a tie the port that was not served last wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = ~last;
    end else begin
      win = bus.req1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= INIT_EN ? ST_INIT : ST_IDLE;
      init_cnt  <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        ST_INIT: begin
          busy_q <= 1'b1;
          // Advance only on edges where the falling-edge drive already has a
          // write up, so every address is written regardless of which clock
          // phase reset was released in.
          if (ram_write) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        ST_IDLE: begin
          if (any_req) begin
            owner     <= win;
            last      <= win;
            lat_we    <= win ? bus.we1    : bus.we0;
            lat_addr  <= win ? bus.addr1  : bus.addr0;
            lat_wdata <= win ? bus.wdata1 : bus.wdata0;
            gnt0_q    <= ~win;
            gnt1_q    <= win;
            busy_q    <= 1'b1;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!lat_we) begin
            rdata_q <= ram_rdata;
          end
          done0_q <= ~owner;
          done1_q <= owner;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM lines change only on the falling edge, so they are stable across the
  // high phase that the RAM's gated write clock uses.
  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ram_write <= 1'b1;
          ram_addr  <= init_cnt;
          ram_wdata <= '0;
        end
        ST_ACCESS: begin
          ram_write <= lat_we;
          ram_addr  <= lat_addr;
          if (lat_we) begin
            ram_wdata <= lat_wdata;
          end
        end
        default: begin
          ram_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: self-checking bench for ram_arbiter_2p with a behavioural
// 4x16 RAM (gated write on rising edge) and a word-array reference model.
module tb_ram_arbiter_2p;
  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          clear;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ram_mem [4];

  ram_arbiter_2p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_arbiter_2p #(.DATA_W(DW), .ADDR_W(AW), .INIT_EN(1'b1)) dut (
    .clk       (clk),
    .clear     (clear),
    .bus       (bus),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: storage clocked by clk & write, combinational read.
  always @(posedge clk) if (ram_write) ram_mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_mem[ram_addr];

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] mdl [4];
  bit            m_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 4; i++) mdl[i] = '0;
    m_last = 1'b1;
  endtask

  // Single-port transaction driver, started and finished with the FSM idle.
  // clean=0 flags a wrong-port pulse, an overlapping gnt/done, a missing done
  // or a pulse longer than one cycle.
  task automatic access(input bit p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output bit clean,
                        output logic [DW-1:0] rd);
    clean = 1'b1;
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
    lat = 0;
    do begin
      step();
      lat++;
      if ((p ? bus.gnt0 : bus.gnt1) || bus.done0 || bus.done1) clean = 1'b0;
    end while (!(p ? bus.gnt1 : bus.gnt0) && lat < 20);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    rd = bus.rdata;
    if (!(p ? bus.done1 : bus.done0) || (p ? bus.done0 : bus.done1) || bus.gnt0 || bus.gnt1)
      clean = 1'b0;
    step();
    if (bus.done0 || bus.done1 || bus.gnt0 || bus.gnt1) clean = 1'b0;
    m_last = p;
  endtask

  task automatic test_reset();
    int            lat;
    bit            clean;
    logic [DW-1:0] rd;
    int            busy_cnt = 0;
    int            wr_cnt = 0;
    int            wr_addr [8];
    bit            bad_data = 1'b0;
    bit            saw_gnt = 1'b0;
    clear = 1'b0;
    step();
    step();
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, ram_write, ram_addr, ram_wdata, bus.rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b wr=%b addr=%0d wdata=%h rdata=%h, required all 0",
               bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, ram_write, ram_addr, ram_wdata, bus.rdata);
    end
    @(negedge clk);
    #1;
    clear    = 1'b1;
    bus.req0 = 1'b1;
    bus.we0  = 1'b0;
    bus.addr0 = 2'd1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.busy) busy_cnt++;
      if (bus.gnt0 || bus.gnt1) saw_gnt = 1'b1;
      if (ram_write) begin
        wr_addr[wr_cnt] = int'(ram_addr);
        if (ram_wdata !== '0) bad_data = 1'b1;
        wr_cnt++;
      end
      if (i == 2) bus.req0 = 1'b0;
    end
    tests++;
    if (busy_cnt !== 4) begin
      fails++; $display("FAIL init_busy_cycles: got %0d, required 4", busy_cnt);
    end
    tests++;
    if (wr_cnt !== 4) begin
      fails++; $display("FAIL init_write_count: got %0d, required 4", wr_cnt);
    end
    for (int i = 0; i < wr_cnt && i < 4; i++) begin
      tests++;
      if (wr_addr[i] !== i) begin
        fails++; $display("FAIL init_addr_%0d: got %0d, required %0d", i, wr_addr[i], i);
      end
    end
    tests++;
    if (bad_data) begin
      fails++; $display("FAIL init_wdata: got nonzero, required 0");
    end
    tests++;
    if (saw_gnt) begin
      fails++; $display("FAIL init_ignores_req: got a grant, required none");
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL idle_busy: got %b, required 0", bus.busy);
    end
    access(1'b0, 1'b0, 2'd2, '0, lat, clean, rd);
    tests++;
    if (lat !== 1 || clean !== 1'b1 || rd !== mdl[2]) begin
      fails++; $display("FAIL init_read_addr2: got lat=%0d clean=%b rdata=%h, required lat=1 clean=1 rdata=%h", lat, clean, rd, mdl[2]);
    end
  endtask

  task automatic test_write_read();
    int            lat;
    bit            clean;
    logic [DW-1:0] rd;
    access(1'b0, 1'b1, 2'd1, 16'hA5F0, lat, clean, rd);
    mdl[1] = 16'hA5F0;
    tests++;
    if (lat !== 1 || clean !== 1'b1) begin
      fails++; $display("FAIL wr_handshake: got lat=%0d clean=%b, required lat=1 clean=1", lat, clean);
    end
    access(1'b0, 1'b0, 2'd1, '0, lat, clean, rd);
    tests++;
    if (lat !== 1 || clean !== 1'b1) begin
      fails++; $display("FAIL rd_handshake: got lat=%0d clean=%b, required lat=1 clean=1", lat, clean);
    end
    tests++;
    if (rd !== mdl[1]) begin
      fails++; $display("FAIL rd_data: got %h, required %h", rd, mdl[1]);
    end
  endtask

  task automatic test_simultaneous();
    int            lat;
    bit            clean;
    logic [DW-1:0] rd;
    int            g0 = 0, g1 = 0, d0 = 0, d1 = 0;
    int            e0, e1;
    bit            overlap = 1'b0;
    bit            first;
    access(1'b1, 1'b0, 2'd0, '0, lat, clean, rd);
    tests++;
    if (lat !== 1 || clean !== 1'b1 || rd !== mdl[0]) begin
      fails++; $display("FAIL p1_read0: got lat=%0d clean=%b rdata=%h, required 1 1 %h", lat, clean, rd, mdl[0]);
    end
    first = ~m_last;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd0; bus.wdata0 = 16'h1111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd3; bus.wdata1 = 16'h3333;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (bus.gnt0 && bus.gnt1) overlap = 1'b1;
      if (bus.gnt0) begin g0 = c; bus.req0 = 1'b0; end
      if (bus.gnt1) begin g1 = c; bus.req1 = 1'b0; end
      if (bus.done0) d0 = c;
      if (bus.done1) d1 = c;
    end
    e0 = first ? 4 : 1;
    e1 = first ? 1 : 4;
    mdl[0] = 16'h1111;
    mdl[3] = 16'h3333;
    m_last = ~first;
    tests++;
    if (g0 !== e0 || g1 !== e1) begin
      fails++; $display("FAIL tie_grant_cycles: got gnt0@%0d gnt1@%0d, required gnt0@%0d gnt1@%0d", g0, g1, e0, e1);
    end
    tests++;
    if (d0 !== e0 + 1 || d1 !== e1 + 1) begin
      fails++; $display("FAIL tie_done_cycles: got done0@%0d done1@%0d, required %0d %0d", d0, d1, e0 + 1, e1 + 1);
    end
    tests++;
    if (overlap) begin
      fails++; $display("FAIL tie_gnt_overlap: got both grants together, required exclusive");
    end
    access(1'b0, 1'b0, 2'd0, '0, lat, clean, rd);
    tests++;
    if (rd !== mdl[0] || clean !== 1'b1) begin
      fails++; $display("FAIL tie_readback0: got %h clean=%b, required %h", rd, clean, mdl[0]);
    end
    access(1'b1, 1'b0, 2'd3, '0, lat, clean, rd);
    tests++;
    if (rd !== mdl[3] || clean !== 1'b1) begin
      fails++; $display("FAIL tie_readback3: got %h clean=%b, required %h", rd, clean, mdl[3]);
    end
  endtask

  // Continuous requests from both ports: grants alternate, one every 3 cycles.
  task automatic test_fairness();
    bit first;
    bit gp;
    bit pend = 1'b0;
    int ng = 0;
    int prev_g = 0;
    first = ~m_last;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd3;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.gnt0 || bus.gnt1) begin
        gp = bus.gnt1;
        tests++;
        if (bus.gnt0 === bus.gnt1 || gp !== (first ^ ng[0])) begin
          fails++; $display("FAIL rr_order_%0d: got gnt0=%b gnt1=%b, required port %0d", ng, bus.gnt0, bus.gnt1, first ^ ng[0]);
        end
        if (ng > 0) begin
          tests++;
          if (c - prev_g !== 3) begin
            fails++; $display("FAIL rr_interval_%0d: got %0d, required 3", ng, c - prev_g);
          end
        end
        prev_g = c;
        pend   = gp;
        m_last = gp;
        ng++;
        if (ng == 6) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
      if (bus.done0 || bus.done1) begin
        tests++;
        if (c !== prev_g + 1 || bus.done1 !== pend || bus.done0 !== ~pend) begin
          fails++; $display("FAIL rr_done: got done0=%b done1=%b at %0d, required port %0d at %0d", bus.done0, bus.done1, c, pend, prev_g + 1);
        end
        tests++;
        if (bus.rdata !== mdl[pend ? 3 : 0]) begin
          fails++; $display("FAIL rr_rdata: got %h, required %h", bus.rdata, mdl[pend ? 3 : 0]);
        end
      end
      if (ng == 6 && c == prev_g + 2) break;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tests++;
    if (ng !== 6) begin
      fails++; $display("FAIL rr_count: got %0d grants, required 6", ng);
    end
  endtask

  task automatic test_abort();
    int            lat;
    bit            clean;
    logic [DW-1:0] rd;
    bit            saw = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 16'hFFFF;
    step();
    tests++;
    if (bus.gnt0 !== 1'b1) begin
      fails++; $display("FAIL abort_gnt: got %b, required 1", bus.gnt0);
    end
    #5;
    tests++;
    if ({ram_write, ram_addr, ram_wdata} !== {1'b1, 2'd2, 16'hFFFF}) begin
      fails++; $display("FAIL abort_ram_drive: got wr=%b addr=%0d wdata=%h, required 1 2 ffff", ram_write, ram_addr, ram_wdata);
    end
    clear    = 1'b0;
    bus.req0 = 1'b0;
    #1;
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, ram_write} !== '0) begin
      fails++; $display("FAIL abort_drop: got gnt=%b%b done=%b%b busy=%b wr=%b, required all 0",
                        bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, ram_write);
    end
    repeat (2) begin
      step();
      if (bus.done0 || bus.done1 || bus.gnt0 || bus.gnt1 || ram_write) saw = 1'b1;
    end
    @(negedge clk);
    #1;
    clear = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done0 || bus.done1 || bus.gnt0 || bus.gnt1) saw = 1'b1;
    end
    tests++;
    if (saw) begin
      fails++; $display("FAIL abort_no_done: got a pulse after abort, required none");
    end
    access(1'b0, 1'b0, 2'd2, '0, lat, clean, rd);
    tests++;
    if (rd !== mdl[2] || lat !== 1 || clean !== 1'b1) begin
      fails++; $display("FAIL abort_rezero: got rdata=%h lat=%0d clean=%b, required %h 1 1", rd, lat, clean, mdl[2]);
    end
  endtask

  task automatic test_port1_repeat();
    int            lat;
    bit            clean;
    logic [DW-1:0] rd;
    int            ng = 0;
    int            prev_g = 0;
    bit            saw0 = 1'b0;
    access(1'b1, 1'b1, 2'd3, 16'h0F0F, lat, clean, rd);
    mdl[3] = 16'h0F0F;
    tests++;
    if (lat !== 1 || clean !== 1'b1) begin
      fails++; $display("FAIL p1_write: got lat=%0d clean=%b, required 1 1", lat, clean);
    end
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd3;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.gnt0 || bus.done0) saw0 = 1'b1;
      if (bus.gnt1) begin
        tests++;
        if (c - prev_g !== (ng == 0 ? 1 : 3)) begin
          fails++; $display("FAIL p1_interval_%0d: got %0d, required %0d", ng, c - prev_g, ng == 0 ? 1 : 3);
        end
        prev_g = c;
        ng++;
        if (ng == 4) bus.req1 = 1'b0;
      end
      if (bus.done1) begin
        tests++;
        if (c !== prev_g + 1 || bus.rdata !== mdl[3]) begin
          fails++; $display("FAIL p1_done_rdata: got %h at %0d, required %h at %0d", bus.rdata, c, mdl[3], prev_g + 1);
        end
      end
      if (ng == 4 && c == prev_g + 2) break;
    end
    bus.req1 = 1'b0;
    m_last = 1'b1;
    tests++;
    if (ng !== 4 || saw0) begin
      fails++; $display("FAIL p1_count: got %0d grants port0_activity=%b, required 4 and 0", ng, saw0);
    end
  endtask

  task automatic test_random();
    int            lat;
    bit            clean;
    logic [DW-1:0] rd;
    bit            p, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 24; i++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 3));
      d = DW'($urandom);
      access(p, w, a, d, lat, clean, rd);
      tests++;
      if (lat !== 1 || clean !== 1'b1) begin
        fails++; $display("FAIL rand_handshake_%0d: got lat=%0d clean=%b, required 1 1", i, lat, clean);
      end
      if (w) begin
        mdl[a] = d;
      end else begin
        tests++;
        if (rd !== mdl[a]) begin
          fails++; $display("FAIL rand_read_%0d: port %0d addr %0d got %h, required %h", i, p, a, rd, mdl[a]);
        end
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    clear      = 1'b0;
    bus.req0   = 1'b0; bus.req1   = 1'b0;
    bus.we0    = 1'b0; bus.we1    = 1'b0;
    bus.addr0  = '0;   bus.addr1  = '0;
    bus.wdata0 = '0;   bus.wdata1 = '0;
    for (int unsigned i = 0; i < 4; i++) ram_mem[i] = DW'($urandom);
    model_reset();
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fairness();
    test_abort();
    test_port1_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
